// File: rtl/apb_slave_regfile.sv
// APB slave register file with programmable wait states, address/alignment error
// checking and a read-only completed-transfer counter in the top word.
module apb_slave_regfile #(
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        pselx,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr
);

  localparam int unsigned IW = $clog2(NUM_REGS);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t          state;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic            write_q;
  logic            err_q;
  logic [CW-1:0]   wcnt;
  logic [31:0]     xfer_cnt;
  logic [31:0]     regs [NUM_REGS];

  logic [31:0]     dec_addr_c;
  logic            dec_write_c;
  logic [IW-1:0]   idx_c;
  logic            err_c;
  logic [31:0]     rd_c;
  logic            finish_c;

  // Zero-wait transfers complete straight out of the setup cycle, so decode the
  // live bus in IDLE and the latched copy everywhere else.
  assign dec_addr_c  = (state == IDLE) ? paddr  : addr_q;
  assign dec_write_c = (state == IDLE) ? pwrite : write_q;
  assign idx_c       = dec_addr_c[IW+1:2];
  assign err_c       = (dec_addr_c[31:IW+2] != BASE_ADDR[31:IW+2])
                    || (dec_addr_c[1:0] != 2'b00)
                    || (dec_write_c && (idx_c == IW'(NUM_REGS - 1)));
  assign rd_c        = (idx_c == IW'(NUM_REGS - 1)) ? xfer_cnt : regs[idx_c];

  // The edge that launches the single pready cycle.
  assign finish_c = ((state == IDLE) && pselx && !penable && (WAIT_STATES == 0))
                 || ((state == ACCESS) && pselx && penable && (wcnt < CW'(2)));

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      wcnt     <= '0;
      xfer_cnt <= '0;
      prdata   <= '0;
      pready   <= 1'b0;
      pslverr  <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[IW'(i)] <= '0;
    end else begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
      case (state)
        IDLE: begin
          if (pselx && !penable) begin
            addr_q  <= paddr;
            write_q <= pwrite;
            wdata_q <= pwdata;
            wcnt    <= CW'(WAIT_STATES);
            state   <= (WAIT_STATES == 0) ? DONE : ACCESS;
          end
        end
        ACCESS: begin
          if (!pselx || !penable) begin
            state <= IDLE;
          end else if (finish_c) begin
            state <= DONE;
          end else begin
            wcnt <= wcnt - CW'(1);
          end
        end
        DONE: begin
          if (!err_q) begin
            if (write_q) regs[idx_c] <= wdata_q;
            xfer_cnt <= xfer_cnt + 32'd1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Response is loaded together with pready; writes leave prdata untouched.
      if (finish_c) begin
        pready  <= 1'b1;
        pslverr <= err_c;
        err_q   <= err_c;
        if (!dec_write_c) prdata <= err_c ? 32'd0 : rd_c;
      end
    end
  end

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
- APB slave register file that sits directly downstream of the AHB-to-APB bridge (bridge_top).
- It consumes the bridge's pselx/penable/pwrite/paddr/pwdata and returns prdata/pready/pslverr.
- It has a programmable number of wait states, address-range and alignment checking, and a read-only completed-transfer counter.
- It replaces the zero-wait APB model so the bridge's wait-state and error paths can be exercised.

Parameters:
- NUM_REGS, 16, number of 32-bit word registers (power of 2, 2..256); index NUM_REGS-1 is the read-only transfer counter.
- WAIT_STATES, 2, access-phase cycles inserted before pready (0..15).
- BASE_ADDR, 32'h8000_0000, byte base address of the register window; must be aligned to NUM_REGS*4.

Ports:
- pclk  input  1  APB clock; all state changes on its rising edge.
- preset  input  1  asynchronous, active-high reset.
- pselx  input  1  slave select from bridge.
- penable  input  1  access-phase strobe.
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  32  byte address.
- pwdata  input  32  write data.
- prdata  output  32  read data, registered.
- pready  output  1  transfer-complete strobe, registered.
- pslverr  output  1  error response, valid only while pready=1, registered.

Behaviour:
- Reset (preset=1, asynchronous): all registers = 0, counter = 0, prdata = 0, pready = 0, pslverr = 0, FSM = IDLE. Reset mid-transfer aborts it with no write.
- Decode: hit = (paddr >= BASE_ADDR) && (paddr < BASE_ADDR + NUM_REGS*4); idx = paddr[log2(NUM_REGS)+1:2].
- Error = !hit, OR paddr[1:0] != 0, OR (pwrite && idx == NUM_REGS-1).
- Decode uses values latched at the end of the setup cycle.
- FSM states:
  - IDLE: pready=0. On pselx=1 && penable=0 (setup cycle T0), latch paddr/pwrite/pwdata, load wait counter = WAIT_STATES, go to ACCESS.
  - ACCESS (T1 onward): if pselx=0 or penable=0, go to IDLE (abort: no write, no count, pready stays 0). Else if counter != 0, decrement. When counter == 0 at a rising edge, assert pready for the next cycle and go to DONE.
  - DONE: pready=1 for exactly one cycle (cycle T1+WAIT_STATES), then go to IDLE.
- Latency: pready is high only in cycle T1+WAIT_STATES. With WAIT_STATES=0, pready is high in T1.
- Load timing:
  - prdata and pslverr load on the same edge that asserts pready.
  - Read OK: prdata = reg[idx], or counter when idx == NUM_REGS-1.
  - Read error: prdata = 0, pslverr = 1.
  - Write (any outcome): prdata holds its previous value.
- Write commit: reg[idx] <= latched pwdata on the edge that ends the DONE cycle, only when no error.
- pslverr: 0 whenever pready = 0.
- Transfer counter (32-bit, wraps from FFFF_FFFF to 0):
  - Increments on the edge ending DONE for every non-error transfer, read or write.
  - A read of the counter returns its value before that transfer's increment.
- Back-to-back: a new setup cycle may occur in the cycle immediately after DONE. IDLE accepts it with no bubble.
- Setup overlapping DONE: if pselx=1 && penable=0 is presented during DONE, it is ignored; the master must re-present it.
- While in ACCESS, changes on paddr, pwrite and pwdata are ignored (latched values are used).

Test Plan:
- Reset: hold preset=1 for 2 cycles, then read every index -> prdata = 0, pslverr = 0, counter = 0.
- Wait-state timing (WAIT_STATES=2):
  - Write 32'hDEAD_BEEF to 8000_0004 -> pready high only in T3, pslverr = 0.
  - Read 8000_0004 -> prdata = DEAD_BEEF in the pready cycle.
  - Read counter at 8000_003C -> 2.
- Errors:
  - Read 9000_0000 -> pslverr = 1, prdata = 0.
  - Write 8000_0006 -> pslverr = 1, no register changes.
  - Write 8000_003C -> pslverr = 1, counter unchanged.
- Abort: drop penable in T2 of a write to 8000_0008 -> pready never asserted, reg[2] stays 0, counter unchanged.
- Back-to-back: four consecutive single writes to indices 0..3 via the bridge burst_write (data 1..4), no idle cycles between APB transfers -> reads return 1, 2, 3, 4; counter = 8 after the reads.
- Zero-wait (WAIT_STATES=0) plus reset mid-ACCESS:
  - Zero-wait transfer -> pready high in T1.
  - Assert preset during ACCESS -> pready = 0 immediately, target register = 0.
